// File: rtl/pipe_skip_adder_pkg.sv
// Shared defaults and the pipeline stage record for pipe_skip_adder.
package pipe_skip_adder_pkg;

  localparam int unsigned DefaultWidth  = 32;
  localparam int unsigned DefaultBlock  = 4;
  localparam int unsigned DefaultStages = 2;

  // One pipeline stage at the default width; the adder declares the same layout sized by WIDTH.
  typedef struct packed {
    logic                    valid;
    logic [DefaultWidth-1:0] sum;
    logic [DefaultWidth-1:0] a;
    logic [DefaultWidth-1:0] bp;
    logic                    carry;
    logic                    sub;
  } stage_rec_t;

endpackage

// File: rtl/pipe_skip_adder_if.sv
// Operand/result handshake bundle for pipe_skip_adder.
interface pipe_skip_adder_if
  import pipe_skip_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/skip_block.sv
// BLOCK-bit ripple adder whose carry-out bypasses the ripple when every bit propagates.
module skip_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] bp,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);
  logic [BLOCK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(BLOCK); i++) begin
      sum[i]   = a[i] ^ bp[i] ^ c[i];
      c[i + 1] = (a[i] & bp[i]) | ((a[i] ^ bp[i]) & c[i]);
    end
    cout = (&(a ^ bp)) ? cin : c[BLOCK];
  end
endmodule

// File: rtl/pipe_skip_adder.sv
// Pipelined carry-skip adder/subtractor, STAGES cycles latency, elastic valid/ready pipe.
// Define PIPE_SKIP_ADDER_SAT_EN to saturate SUM on signed overflow.
module pipe_skip_adder
  import pipe_skip_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned BLOCK  = DefaultBlock,
  parameter int unsigned STAGES = DefaultStages
) (
  input logic              clk,
  input logic              rst,
  pipe_skip_adder_if.slave bus
);
  localparam int unsigned NumBlocks      = WIDTH / BLOCK;
  localparam int unsigned BlocksPerStage = NumBlocks / STAGES;
  localparam int unsigned StageBits      = WIDTH / STAGES;

  if ((WIDTH % BLOCK) != 0 || (NumBlocks % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_skip_adder: WIDTH must split into BLOCK-bit blocks evenly across STAGES");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;
    logic             carry;
    logic             sub;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t src     [STAGES];
  stage_t nxt     [STAGES];

  logic [STAGES-1:0]    load;
  logic [STAGES-1:0]    leave;
  logic [WIDTH-1:0]     blk_sum;
  logic [NumBlocks-1:0] blk_cout;
  logic                 ovf;

  // Stage k adds its slice from src[k]: the live inputs for stage 0, the previous register otherwise.
  always_comb begin
    src[0]       = '0;
    src[0].valid = bus.in_valid;
    src[0].a     = bus.a;
    src[0].bp    = bus.sub ? ~bus.b : bus.b;
    src[0].carry = bus.sub | bus.cin;
    src[0].sub   = bus.sub;
    for (int k = 1; k < int'(STAGES); k++) begin
      src[k] = stage_q[k - 1];
    end
  end

  for (genvar j = 0; j < int'(NumBlocks); j++) begin : g_blk
    localparam int unsigned StageIdx = j / BlocksPerStage;
    logic blk_cin;
    if ((j % BlocksPerStage) == 0) begin : g_first
      assign blk_cin = src[StageIdx].carry;
    end else begin : g_chain
      assign blk_cin = blk_cout[j - 1];
    end
    skip_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a   (src[StageIdx].a[j*BLOCK +: BLOCK]),
      .bp  (src[StageIdx].bp[j*BLOCK +: BLOCK]),
      .cin (blk_cin),
      .sum (blk_sum[j*BLOCK +: BLOCK]),
      .cout(blk_cout[j])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt[k]                                 = src[k];
      nxt[k].sum[k*StageBits +: StageBits]   = blk_sum[k*StageBits +: StageBits];
      nxt[k].carry                           = blk_cout[(k + 1)*BlocksPerStage - 1];
    end
  end

  // Walk from the output back so a stage may refill in the same cycle its content moves on.
  always_comb begin
    load               = '0;
    leave              = '0;
    leave[STAGES-1]    = stage_q[STAGES-1].valid & bus.out_ready;
    load[STAGES-1]     = src[STAGES-1].valid & (~stage_q[STAGES-1].valid | leave[STAGES-1]);
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      leave[k] = stage_q[k].valid & load[k + 1];
      load[k]  = src[k].valid & (~stage_q[k].valid | leave[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          stage_q[k] <= nxt[k];
        end else if (leave[k]) begin
          stage_q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = ~stage_q[0].valid | leave[0];
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.cout      = stage_q[STAGES-1].carry;
  assign ovf           = (stage_q[STAGES-1].a[WIDTH-1] == stage_q[STAGES-1].bp[WIDTH-1]) &
                         (stage_q[STAGES-1].sum[WIDTH-1] != stage_q[STAGES-1].a[WIDTH-1]);
  assign bus.ovf       = ovf;

`ifdef PIPE_SKIP_ADDER_SAT_EN
  assign bus.sum = ovf ? {stage_q[STAGES-1].a[WIDTH-1], {(WIDTH-1){~stage_q[STAGES-1].a[WIDTH-1]}}}
                       : stage_q[STAGES-1].sum;
`else
  assign bus.sum = stage_q[STAGES-1].sum;
`endif

endmodule
